mmio_uart_tx: RTL and testbench

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/mmio_uart_tx.sv | 138 +++++++++++++
 tb/tb_mmio_uart_tx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes into a small FIFO, STATUS
// reports overflow/active/empty/full, and a four-state FSM shifts bytes out LSB first.
module mmio_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic        we,
  output logic [31:0] dout,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned AW          = $clog2(FIFO_DEPTH);
  localparam int unsigned BW          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        r_state;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [7:0]    r_shift;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit_cnt;
  logic          r_overflow;

  logic w_sel_data;
  logic w_sel_status;
  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_baud_done;
  logic w_active;
  logic w_unused_din;

  assign w_sel_data   = (addr == BASE_ADDR);
  assign w_sel_status = (addr == STATUS_ADDR);
  // Pointers carry one extra wrap bit, so equal pointers mean empty and a
  // difference of FIFO_DEPTH means full.
  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_full       = ((r_wr_ptr - r_rd_ptr) == (AW + 1)'(FIFO_DEPTH));
  assign w_push       = we && w_sel_data && !w_full;
  assign w_pop        = (r_state == S_IDLE) && !w_empty;
  assign w_baud_done  = (r_baud == BAUD_LAST);
  assign w_active     = (r_state != S_IDLE);
  assign busy         = w_active || !w_empty;
  assign w_unused_din = ^din[31:8];

  // NOTE: the FIFO storage has no reset; emptiness is defined by the pointers,
  // so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= din[7:0];
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      // A rejected push and a clear cannot both hit on one edge here, but set still takes priority.
      if (we && w_sel_data && w_full)          r_overflow <= 1'b1;
      else if (we && w_sel_status && din[3])   r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_baud    <= '0;
      r_bit_cnt <= '0;
      tx        <= 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr[AW-1:0]];
            r_state <= S_START;
            tx      <= 1'b0;
          end
        end
        S_START: begin
          if (w_baud_done) begin
            r_baud    <= '0;
            r_bit_cnt <= '0;
            tx        <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_state   <= S_DATA;
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        S_DATA: begin
          if (w_baud_done) begin
            r_baud <= '0;
            if (r_bit_cnt == 3'd7) begin
              tx      <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              tx        <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        S_STOP: begin
          if (w_baud_done) begin
            r_baud  <= '0;
            r_state <= S_IDLE;
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    dout = '0;
    if (w_sel_status) dout = {28'b0, r_overflow, w_active, w_empty, w_full};
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: table-driven register vectors plus a
// byte scoreboard fed by a small FIFO/frame model and drained by a serial receiver.
module tb_mmio_uart_tx;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] STAT  = 32'h0000_1004;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] din = '0;
  logic        we = 1'b0;
  logic [31:0] dout;
  logic        tx;
  logic        busy;

  mmio_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk    (clk),
    .n_reset(n_reset),
    .addr   (addr),
    .din    (din),
    .we     (we),
    .dout   (dout),
    .tx     (tx),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  int         m_count      = 0;
  int         m_frame_left = 0;
  bit         m_ovf        = 1'b0;
  logic [7:0] sb_q[$];
  int         last_start   = -1;
  bit         rx_done      = 1'b0;

  typedef struct {
    string       name;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    bit          wr_en;
    logic [31:0] rd_addr;
    logic [31:0] mask;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_count      = 0;
    m_frame_left = 0;
    m_ovf        = 1'b0;
    last_start   = -1;
    sb_q.delete();
  endtask

  // One clock: model sees the same pre-edge inputs as the DUT.
  task automatic step();
    logic [31:0] a;
    logic [31:0] d;
    logic        w;
    bit          full;
    bit          pop;
    a = addr;
    d = din;
    w = we;
    @(posedge clk);
    full = (m_count == DEPTH);
    pop  = (m_frame_left == 0) && (m_count > 0);
    if (w && a == BASE) begin
      if (!full) begin
        sb_q.push_back(d[7:0]);
        m_count++;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (w && a == STAT && d[3]) begin
      m_ovf = 1'b0;
    end
    if (pop) begin
      m_count--;
      m_frame_left = 10 * CPB;
    end else if (m_frame_left > 0) begin
      m_frame_left--;
    end
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    step();
    we   = 1'b0;
  endtask

  function automatic logic model_busy();
    return (m_frame_left != 0) || (m_count != 0);
  endfunction

  task automatic run_vec(input int i);
    if (tbl[i].wr_en) store(tbl[i].wr_addr, tbl[i].wr_data);
    else step();
    addr = tbl[i].rd_addr;
    #1;
    check(tbl[i].name, dout & tbl[i].mask, tbl[i].exp);
  endtask

  // Samples each bit mid-period and compares the byte with the scoreboard head.
  task automatic recv_frame();
    int         t;
    int         start;
    logic [7:0] b;
    t = 0;
    while (tx !== 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++;
      failures++;
      $display("FAIL rx_timeout: got no start bit expected one within 200 cycles");
      return;
    end
    start = cyc;
    if (last_start >= 0) check("frame_gap", start - last_start, 10 * CPB + 1);
    last_start = start;
    repeat (CPB / 2) @(negedge clk);
    check("rx_start_bit", {31'b0, tx}, 32'h0);
    for (int k = 0; k < 8; k++) begin
      repeat (CPB) @(negedge clk);
      b[k] = tx;
    end
    repeat (CPB) @(negedge clk);
    check("rx_stop_bit", {31'b0, tx}, 32'h1);
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL rx_unexpected: got byte %h expected none", b);
    end else begin
      check("rx_byte", {24'b0, b}, {24'b0, sb_q.pop_front()});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] bits;
    logic [7:0] byte_exp;
    bit         seen_low;

    tbl[0] = '{"status_after_reset", 32'h0,     32'h0,        1'b0, STAT,         32'hFFFF_FFFF, 32'h2};
    tbl[1] = '{"unmapped_low_read",  32'h0FFC,  32'h0000_00AA, 1'b1, 32'h0000_0FFC, 32'hFFFF_FFFF, 32'h0};
    tbl[2] = '{"unmapped_high_read", 32'h1008,  32'h0000_00BB, 1'b1, 32'h0000_1008, 32'hFFFF_FFFF, 32'h0};
    tbl[3] = '{"unmapped_no_fifo",   32'h0,     32'h0,        1'b0, STAT,         32'hFFFF_FFFF, 32'h2};
    tbl[4] = '{"txdata_reads_zero",  32'h0,     32'h0,        1'b0, BASE,         32'hFFFF_FFFF, 32'h0};
    tbl[5] = '{"status_read_only",   STAT,      32'h0000_0007, 1'b1, STAT,         32'hFFFF_FFFF, 32'h2};
    tbl[6] = '{"ovf_kept_on_zero",   STAT,      32'h0,        1'b1, STAT,         32'h0000_0008, 32'h8};
    tbl[7] = '{"ovf_cleared",        STAT,      32'h0000_0008, 1'b1, STAT,         32'h0000_0008, 32'h0};

    // Reset behaviour, checked while asserted and after release
    addr = STAT;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check("reset_tx", {31'b0, tx}, 32'h1);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_status", dout, 32'h2);
    #1 n_reset = 1'b1;
    step();
    check("post_reset_tx", {31'b0, tx}, 32'h1);
    check("post_reset_busy", {31'b0, busy}, 32'h0);

    for (int i = 0; i < 6; i++) run_vec(i);

    // Single frame, exact bit timing
    store(BASE, 32'hFFFF_FF55);
    check("push_tx_still_idle", {31'b0, tx}, 32'h1);
    check("push_busy", {31'b0, busy}, {31'b0, model_busy()});
    byte_exp = sb_q.pop_front();
    bits = {1'b1, byte_exp, 1'b0};
    for (int i = 0; i < 10 * CPB; i++) begin
      step();
      check($sformatf("frame_bit%0d_cyc%0d", i / CPB, i % CPB), {31'b0, tx}, {31'b0, bits[i / CPB]});
    end
    step();
    check("frame_end_busy", {31'b0, busy}, 32'h0);
    check("frame_end_tx", {31'b0, tx}, 32'h1);
    addr = STAT;
    #1;
    check("frame_end_status", dout, 32'h2);

    // Burst of six stores: one pops immediately, four fill the FIFO, the last is dropped
    rx_done = 1'b0;
    fork
      begin
        for (int i = 1; i <= 6; i++) store(BASE, i);
        while (!rx_done) step();
      end
      begin
        for (int f = 0; f < 5; f++) recv_frame();
        rx_done = 1'b1;
      end
    join
    check("burst_all_received", sb_q.size(), 32'h0);
    addr = STAT;
    #1;
    check("burst_ovf_set", dout & 32'h8, 32'h8);
    check("burst_busy_tail", {31'b0, busy}, {31'b0, model_busy()});
    repeat (4) step();
    check("burst_busy_done", {31'b0, busy}, 32'h0);

    run_vec(6);
    run_vec(7);

    // Reset in the middle of data bit 3 with two bytes still queued
    store(BASE, 32'h00);
    store(BASE, 32'hAA);
    store(BASE, 32'h55);
    repeat (15) step();
    addr = STAT;
    #2;
    check("mid_frame_tx_low", {31'b0, tx}, 32'h0);
    n_reset = 1'b0;
    #1;
    model_reset();
    check("abort_tx_high", {31'b0, tx}, 32'h1);
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_status", dout, 32'h2);
    #3 n_reset = 1'b1;
    seen_low = 1'b0;
    for (int i = 0; i < 120; i++) begin
      step();
      if (tx !== 1'b1) seen_low = 1'b1;
    end
    check("no_frames_after_abort", {31'b0, seen_low}, 32'h0);
    check("abort_status_later", dout, 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
